// File: rtl/enc_period_gen2.sv
// enc_period_gen2: quadrature quarter-period history, full-period sum and acceleration taps per encoder channel
module enc_period_gen2 #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    parameter int SHIFT = 4,
    parameter int FILT  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a,
    input  logic                   b,
    input  logic                   err_clr,
    output logic [WIDTH-SHIFT-1:0] period,
    output logic                   period_ovf,
    output logic                   period_valid,
    output logic                   dir,
    output logic [WIDTH-SHIFT-1:0] qtr_new,
    output logic [WIDTH-SHIFT-1:0] qtr_old,
    output logic [WIDTH-SHIFT-1:0] t_cur,
    output logic                   t_ovf,
    output logic                   edge_strobe,
    output logic                   seq_err
);
    localparam int OW = WIDTH - SHIFT;
    localparam int SW = WIDTH + 3;
    localparam int FW = FILT > 0 ? $clog2(FILT + 1) : 1;
    localparam int VW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [1:0]       s1, s2, f, fp;
    logic [FW-1:0]    fc [2];
    logic [2:0]       st;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hist [DEPTH];
    logic [VW-1:0]    vcnt;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] psat;
    logic             anymax, sat, ovf_n, armed, da, db, both, ev, fwd, same;

    // st walks the synchroniser fill, then loads fp before edges are armed
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            f <= '0;
            fp <= '0;
            fc[0] <= '0;
            fc[1] <= '0;
            st <= '0;
        end else begin
            s1 <= {b, a};
            s2 <= s1;
            fp <= f;
            st <= (st == 3'd4) ? st : st + 3'd1;
            for (int i = 0; i < 2; i++)
                if (st < 3'd3) begin
                    f[i] <= s2[i];
                    fc[i] <= '0;
                end else if (s2[i] == f[i])
                    fc[i] <= '0;
                else if (fc[i] >= FW'(FILT)) begin
                    f[i] <= s2[i];
                    fc[i] <= '0;
                end else
                    fc[i] <= fc[i] + FW'(1);
        end

    assign armed = (st == 3'd4);
    assign da    = f[0] ^ fp[0];
    assign db    = f[1] ^ fp[1];
    assign both  = armed & da & db;
    assign ev    = armed & (da ^ db);
    assign fwd   = da ? (f[0] ^ f[1]) : ~(f[0] ^ f[1]);
    assign same  = (fwd == dir);

    always_comb begin
        sum = SW'(cnt);
        anymax = (cnt == MAX);
        for (int i = 0; i < DEPTH - 1; i++) begin
            sum = sum + SW'(hist[i]);
            anymax = anymax | (hist[i] == MAX);
        end
    end

    assign sat   = sum > SW'(MAX);
    assign psat  = sat ? MAX : sum[WIDTH-1:0];
    assign ovf_n = sat | anymax;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt <= MAX;
            for (int i = 0; i < DEPTH; i++) hist[i] <= MAX;
            period <= '1;
            period_ovf <= 1'b1;
            qtr_new <= '1;
            qtr_old <= '1;
            vcnt <= '0;
            dir <= 1'b0;
            seq_err <= 1'b0;
            edge_strobe <= 1'b0;
        end else begin
            edge_strobe <= ev;
            seq_err <= both | (seq_err & ~err_clr);
            if (ev) begin
                cnt <= '0;
                hist[0] <= cnt;
                qtr_new <= OW'(cnt >> SHIFT);
                qtr_old <= OW'(hist[DEPTH-1] >> SHIFT);
                if (same) begin
                    for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
                    period <= OW'(psat >> SHIFT);
                    period_ovf <= ovf_n;
                    vcnt <= (vcnt == VW'(DEPTH)) ? vcnt : vcnt + VW'(1);
                end else begin
                    // reversal: older entries belong to the other direction
                    for (int i = 1; i < DEPTH; i++) hist[i] <= MAX;
                    dir <= fwd;
                    vcnt <= VW'(1);
                    period <= '1;
                    period_ovf <= 1'b1;
                end
            end else begin
                cnt <= (cnt == MAX) ? cnt : cnt + WIDTH'(1);
                if (cnt >= hist[DEPTH-1]) begin
                    period <= OW'(psat >> SHIFT);
                    period_ovf <= ovf_n;
                end
                if (cnt == MAX) period_ovf <= 1'b1;
            end
        end

    assign period_valid = (vcnt == VW'(DEPTH));
    assign t_cur        = OW'(cnt >> SHIFT);
    assign t_ovf        = (cnt == MAX);
endmodule
